// File: rtl/ex_fwd_mdu_if.sv
// EX-stage operand/MDU bundle: forwarding sources, MDU command and HI/LO results.
// The master side drives the pipeline inputs; the slave side is the ex_fwd_mdu block.
interface ex_fwd_mdu_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          flush;
    logic          op_valid;
    logic [2:0]    mdu_op;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          busy;
    logic          stall;
    logic          done;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    modport master (
        output flush, op_valid, mdu_op, rs_addr, rt_addr, rs_data, rt_data,
               mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data,
        input  opa, opb, busy, stall, done, hi, lo
    );

    modport slave (
        input  flush, op_valid, mdu_op, rs_addr, rt_addr, rs_data, rt_data,
               mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data,
        output opa, opb, busy, stall, done, hi, lo
    );
endinterface

// File: rtl/ex_fwd_mdu.sv
// EX-stage operand forwarding plus iterative MULT/DIV unit with HI/LO registers.
// Define EX_MDU_SIGNED_EN to give MULT/DIV two's-complement semantics.
module ex_fwd_mdu #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    ex_fwd_mdu_if.slave bus
);
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic            div_q, div_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;

    logic [DW-1:0]   fwd_a, fwd_b;
    logic            is_mul, is_div, sgn;
    logic [DW:0]     mul_sum;
    logic [DW:0]     div_sh;
    logic [DW:0]     div_diff;
    logic [2*DW-1:0] prod;

    function automatic logic [DW-1:0] apply_sign(input logic [DW-1:0] v, input logic neg);
        logic signed [DW-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    function automatic logic [2*DW-1:0] apply_sign_w(input logic [2*DW-1:0] v, input logic neg);
        logic signed [2*DW-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    // MEM beats WB; register 0 is never forwarded
    always_comb begin
        fwd_a = bus.rs_data;
        if (bus.mem_we && bus.mem_addr != '0 && bus.mem_addr == bus.rs_addr)
            fwd_a = bus.mem_data;
        else if (bus.wb_we && bus.wb_addr != '0 && bus.wb_addr == bus.rs_addr)
            fwd_a = bus.wb_data;

        fwd_b = bus.rt_data;
        if (bus.mem_we && bus.mem_addr != '0 && bus.mem_addr == bus.rt_addr)
            fwd_b = bus.mem_data;
        else if (bus.wb_we && bus.wb_addr != '0 && bus.wb_addr == bus.rt_addr)
            fwd_b = bus.wb_data;
    end

    always_comb begin
        is_mul = (bus.mdu_op == OP_MULTU) || (bus.mdu_op == OP_MULT);
        is_div = (bus.mdu_op == OP_DIVU) || (bus.mdu_op == OP_DIV);
`ifdef EX_MDU_SIGNED_EN
        sgn = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_DIV);
`else
        sgn = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;

        mul_sum  = {1'b0, acc_q} + {1'b0, (b_q[0] ? a_q : {DW{1'b0}})};
        div_sh   = {acc_q, b_q[DW-1]};
        div_diff = div_sh - {1'b0, a_q};
        prod     = {acc_q, b_q};

        // a holds |Rt| (multiplicand/divisor), b holds |Rs| (multiplier/dividend)
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid && !bus.flush) begin
                    if (is_mul || is_div) begin
                        a_d     = apply_sign(fwd_b, sgn && fwd_b[DW-1]);
                        b_d     = apply_sign(fwd_a, sgn && fwd_a[DW-1]);
                        acc_d   = '0;
                        cnt_d   = CW'(DW);
                        div_d   = is_div;
                        neg_d   = sgn && (fwd_a[DW-1] ^ fwd_b[DW-1]);
                        rneg_d  = sgn && fwd_a[DW-1];
                        dz_d    = (fwd_b == '0);
                        state_d = is_div ? S_DIV : S_MUL;
                    end else if (bus.mdu_op == OP_MTHI) begin
                        hi_d = fwd_a;
                    end else if (bus.mdu_op == OP_MTLO) begin
                        lo_d = fwd_a;
                    end
                end
            end
            S_MUL: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    {acc_d, b_d} = {mul_sum, b_q[DW-1:1]};
                    cnt_d        = cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_d = S_DONE;
                end
            end
            S_DIV: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!div_diff[DW]) begin
                        acc_d = div_diff[DW-1:0];
                        b_d   = {b_q[DW-2:0], 1'b1};
                    end else begin
                        acc_d = div_sh[DW-1:0];
                        b_d   = {b_q[DW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    if (div_q) begin
                        lo_d = dz_q ? {DW{1'b1}} : apply_sign(b_q, neg_q);
                        hi_d = apply_sign(acc_q, rneg_q);
                    end else begin
                        {hi_d, lo_d} = apply_sign_w(prod, neg_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.opa   = fwd_a;
    assign bus.opb   = fwd_b;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = (state_q == S_DONE) && !bus.flush;
    assign bus.stall = bus.op_valid && (state_q != S_IDLE) && (bus.mdu_op != 3'b000);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_ex_fwd_mdu.sv
// Bench for ex_fwd_mdu: directed literal cases plus randomized traffic against
// an arithmetic reference model checked on every cycle.
module tb_ex_fwd_mdu;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    ex_fwd_mdu_if #(.DW(DW), .AW(AW)) bus ();

    ex_fwd_mdu #(.DW(DW), .AW(AW), .CW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_left;

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
        if (bus.mem_we && bus.mem_addr != 5'd0 && bus.mem_addr == a) return bus.mem_data;
        if (bus.wb_we && bus.wb_addr != 5'd0 && bus.wb_addr == a) return bus.wb_data;
        return rf;
    endfunction

    // {hi, lo} for a MULT/DIV op computed with plain integer arithmetic
    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic   sg;
        logic [63:0] p;
`ifdef EX_MDU_SIGNED_EN
        sg = (op == 3'd3) || (op == 3'd4);
`else
        sg = 1'b0;
`endif
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        if (op == 3'd1 || op == 3'd3) begin
            p = 64'(sa * sb);
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_res  <= '0;
            m_left <= 0;
        end else if (m_left > 0) begin
            if (bus.flush) begin
                m_left <= 0;
            end else begin
                if (m_left == 1) begin
                    m_hi <= m_res[63:32];
                    m_lo <= m_res[31:0];
                end
                m_left <= m_left - 1;
            end
        end else if (bus.op_valid && !bus.flush) begin
            case (bus.mdu_op)
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    m_res  <= calc(bus.mdu_op, fwd(bus.rs_addr, bus.rs_data), fwd(bus.rt_addr, bus.rt_data));
                    m_left <= DW + 1;
                end
                3'd5: m_hi <= fwd(bus.rs_addr, bus.rs_data);
                3'd6: m_lo <= fwd(bus.rs_addr, bus.rs_data);
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("opa", 64'(bus.opa), 64'(fwd(bus.rs_addr, bus.rs_data)));
            chk("opb", 64'(bus.opb), 64'(fwd(bus.rt_addr, bus.rt_data)));
            chk("busy", 64'(bus.busy), 64'(m_left > 0));
            chk("done", 64'(bus.done), 64'(m_left == 1 && !bus.flush));
            chk("stall", 64'(bus.stall), 64'(bus.op_valid && m_left > 0 && bus.mdu_op != 3'd0));
            chk("hi", 64'(bus.hi), 64'(m_hi));
            chk("lo", 64'(bus.lo), 64'(m_lo));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20));
            3: return 32'h8000_0000;
            4: return 32'h0 - 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic quiet();
        bus.op_valid = 1'b0;
        bus.mdu_op   = 3'd0;
        bus.flush    = 1'b0;
        bus.mem_we   = 1'b0;
        bus.wb_we    = 1'b0;
        bus.rs_addr  = 5'd1;
        bus.rt_addr  = 5'd2;
    endtask

    // Issue one op from idle, return cycles from accept edge to done pulse
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(posedge clk); #1;
        quiet();
        bus.op_valid = 1'b1;
        bus.mdu_op   = op;
        bus.rs_data  = a;
        bus.rt_data  = b;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.mdu_op   = 3'd0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int nst;
        int ndone;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        quiet();
        bus.rs_data  = '0;
        bus.rt_data  = '0;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", 64'(bus.hi), 64'h0);
        chk("rst_lo", 64'(bus.lo), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_stall", 64'(bus.stall), 64'h0);
        chk("rst_done", 64'(bus.done), 64'h0);
        rst_n = 1'b1;

        // forwarding priority
        @(posedge clk); #1;
        bus.rs_addr = 5'd3; bus.rt_addr = 5'd3; bus.rs_data = 32'h11; bus.rt_data = 32'h22;
        bus.mem_we = 1'b1; bus.mem_addr = 5'd3; bus.mem_data = 32'hAA;
        bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hBB;
        #1 chk("fwd_mem", 64'(bus.opa), 64'hAA);
        chk("fwd_mem_b", 64'(bus.opb), 64'hAA);
        bus.mem_addr = 5'd0;
        #1 chk("fwd_wb", 64'(bus.opa), 64'hBB);
        bus.wb_addr = 5'd0;
        #1 chk("fwd_rf", 64'(bus.opa), 64'h11);
        chk("fwd_rf_b", 64'(bus.opb), 64'h22);

        run_op(3'd1, 32'd7, 32'd6, lat);
        chk("multu7x6_lat", 64'(lat), 64'(DW));
        chk("multu7x6_hi", 64'(bus.hi), 64'h0);
        chk("multu7x6_lo", 64'(bus.lo), 64'd42);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("multu_max_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("multu_max_lo", 64'(bus.lo), 64'h0000_0001);
        run_op(3'd2, 32'd100, 32'd7, lat);
        chk("divu100_7_lat", 64'(lat), 64'(DW));
        chk("divu100_7_lo", 64'(bus.lo), 64'd14);
        chk("divu100_7_hi", 64'(bus.hi), 64'd2);
        run_op(3'd2, 32'd5, 32'd0, lat);
        chk("divu5_0_lat", 64'(lat), 64'(DW));
        chk("divu5_0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        chk("divu5_0_hi", 64'(bus.hi), 64'd5);

        // stall window: ADD passes, MFHI waits until the unit is idle again
        @(posedge clk); #1;
        quiet();
        bus.op_valid = 1'b1; bus.mdu_op = 3'd1; bus.rs_data = 32'd3; bus.rt_data = 32'd4;
        @(posedge clk); #1;
        bus.mdu_op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("add_nostall", 64'(bus.stall), 64'h0);
        end
        @(posedge clk); #1;
        bus.mdu_op = 3'd7;
        nst = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.stall) nst++;
            else break;
        end
        chk("mfhi_stall_cycles", 64'(nst), 64'(DW - 4));
        chk("mfhi_release_busy", 64'(bus.busy), 64'h0);
        @(posedge clk); #1;
        quiet();

        // MULT/DIV codes: signed only when the option is built in
        run_op(3'd3, 32'hFFFF_FFFD, 32'd5, lat);
`ifdef EX_MDU_SIGNED_EN
        chk("mult_m3x5_hi", 64'(bus.hi), 64'hFFFF_FFFF);
`else
        chk("mult_m3x5_hi", 64'(bus.hi), 64'h4);
`endif
        chk("mult_m3x5_lo", 64'(bus.lo), 64'hFFFF_FFF1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, lat);
`ifdef EX_MDU_SIGNED_EN
        chk("div_m7_2_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_m7_2_hi", 64'(bus.hi), 64'hFFFF_FFFF);
`else
        chk("div_m7_2_lo", 64'(bus.lo), 64'h7FFF_FFFC);
        chk("div_m7_2_hi", 64'(bus.hi), 64'h1);
`endif

        // flush mid-DIVU leaves HI/LO alone and never pulses done
        @(posedge clk); #1;
        quiet();
        bus.op_valid = 1'b1; bus.mdu_op = 3'd5; bus.rs_data = 32'h1234;
        @(posedge clk); #1;
        chk("mthi", 64'(bus.hi), 64'h1234);
        bus.mdu_op = 3'd2; bus.rs_data = 32'd1000; bus.rt_data = 32'd3;
        @(posedge clk); #1;
        bus.op_valid = 1'b0; bus.mdu_op = 3'd0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        if (bus.done) ndone++;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'h0);
        chk("flush_hi", 64'(bus.hi), 64'h1234);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("flush_no_done", 64'(ndone), 64'h0);

        // flush in idle blocks acceptance
        @(posedge clk); #1;
        bus.op_valid = 1'b1; bus.mdu_op = 3'd1; bus.flush = 1'b1;
        @(posedge clk); #1;
        quiet();
        chk("flush_idle_block", 64'(bus.busy), 64'h0);

        // async reset in the middle of a multiply
        @(posedge clk); #1;
        bus.op_valid = 1'b1; bus.mdu_op = 3'd1; bus.rs_data = 32'd9; bus.rt_data = 32'd9;
        @(posedge clk); #1;
        quiet();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_hi", 64'(bus.hi), 64'h0);
        chk("rst_mid_lo", 64'(bus.lo), 64'h0);
        chk("rst_mid_busy", 64'(bus.busy), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // randomized traffic, checked each cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.op_valid = 1'($urandom_range(0, 1));
            bus.mdu_op   = 3'($urandom_range(0, 7));
            bus.flush    = ($urandom_range(0, 59) == 0);
            bus.rs_addr  = 5'($urandom_range(0, 3));
            bus.rt_addr  = 5'($urandom_range(0, 3));
            bus.rs_data  = rnd_data();
            bus.rt_data  = rnd_data();
            bus.mem_we   = 1'($urandom_range(0, 1));
            bus.mem_addr = 5'($urandom_range(0, 3));
            bus.mem_data = rnd_data();
            bus.wb_we    = 1'($urandom_range(0, 1));
            bus.wb_addr  = 5'($urandom_range(0, 3));
            bus.wb_data  = rnd_data();
        end
        @(posedge clk); #1;
        quiet();
        repeat (40) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ex_fwd_mdu.md
Name: ex_fwd_mdu

Overview:
Parametrised execute-stage operand forwarding unit with an iterative multiply/divide unit (MDU) and HI/LO registers, for the 5-stage MIPS pipeline. It resolves Rs/Rt operands from the MEM and WB stages with defined priority. It launches multi-cycle MULT/DIV operations on the forwarded operands and raises a stall towards the hazard unit while a result or HI/LO access is pending.

Parameters:
DW, 32, datapath width in bits (≥8, even)
AW, 5, register address width
CW, 6, iteration counter width (must satisfy 2^CW > DW)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous abort of in-flight MDU op
op_valid  in  1  EX-stage instruction valid
mdu_op  in  3  000 none, 001 MULTU, 010 DIVU, 011 MULT, 100 DIV, 101 MTHI, 110 MTLO, 111 MFHI/MFLO read
rs_addr  in  AW  EX source 1 address
rt_addr  in  AW  EX source 2 address
rs_data  in  DW  register file value for Rs
rt_data  in  DW  register file value for Rt
mem_we  in  1  MEM stage writes register
mem_addr  in  AW  MEM destination
mem_data  in  DW  MEM ALU result
wb_we  in  1  WB stage writes register
wb_addr  in  AW  WB destination
wb_data  in  DW  WB write data
opa  out  DW  forwarded Rs operand (combinational)
opb  out  DW  forwarded Rt operand (combinational)
busy  out  1  MDU in MUL, DIV or DONE state
stall  out  1  hold IF/ID/EX this cycle
done  out  1  one-cycle pulse: HI/LO update at end of this cycle
hi  out  DW  HI register
lo  out  DW  LO register

Behaviour:
- Forwarding, per operand (shown for opa): if mem_we && mem_addr!=0 && mem_addr==rs_addr, then mem_data. Else if wb_we && wb_addr!=0 && wb_addr==rs_addr, then wb_data. Else rs_data. MEM always wins; there is no zero-output case. opb is identical using rt_*.
- Reset: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, stall=0, internal operand/accumulator registers 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE: op_valid && mdu_op∈{MULTU,MULT} latches opa/opb, loads counter=DW and clears the accumulator, then goes to MUL. The DIVU/DIV codes do the same but go to DIV. MTHI/MTLO write opa into hi/lo at the edge and stay in IDLE.
- MUL: radix-2 shift-add, one multiplier bit per cycle, counter decrements. Final iteration at counter==1, then to DONE.
- DIV: restoring division, one quotient bit per cycle, same counter rule, then to DONE.
- DONE: done=1. At the edge, hi/lo are written (MUL: hi=product[2DW-1:DW], lo=product[DW-1:0]; DIV: lo=quotient, hi=remainder), then to IDLE.
- Latency: accept edge E0; done high in the cycle after E0+DW; hi/lo valid after E0+DW+1. busy is high from after E0 to E0+DW+1 inclusive.
- Divide by zero (unsigned): lo={DW{1}}, hi=dividend. No exception, same latency.
- stall = op_valid && busy && mdu_op!=000. Any MDU/HI/LO instruction waits while busy. Non-MDU instructions proceed.
- A new MDU op is accepted in the same cycle the FSM returns to IDLE, not in DONE.
- flush: in MUL/DIV/DONE, return to IDLE at the next edge with hi/lo unchanged and no done pulse. flush in IDLE blocks acceptance that cycle. flush has priority over the DONE write.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro EX_MDU_SIGNED_EN.
- Defined: MULT/DIV take two's-complement operands. Magnitudes are computed at accept, and the sign is applied to the result in DONE. Quotient sign = xor of operand signs; remainder sign = dividend sign.
- Signed divide by zero: lo={DW{1}}, hi=dividend.
- Not defined: codes 011/100 behave exactly as MULTU/DIVU.

Test Plan:
- Forwarding: rs_addr=3, mem_we=1 mem_addr=3 mem_data=0xAA, wb_we=1 wb_addr=3 wb_data=0xBB → opa=0xAA. Repeat with mem_addr=0 and wb_addr=3 → opa=0xBB. Repeat with wb_addr=0 too → opa=rs_data.
- MULTU 7×6 (DW=32) → done pulse 33 cycles after accept edge; hi=0, lo=42. With 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 → lo=14, hi=2. DIVU 5/0 → lo=0xFFFFFFFF, hi=5. Both with DW+1-cycle latency.
- Issue MFHI (op 111) 5 cycles after MULTU accept → stall high until the cycle the FSM returns to IDLE, then low. An ADD in the same window → stall=0.
- flush 10 cycles into DIVU with hi=0x1234 → no done pulse, hi stays 0x1234, busy=0 next cycle. rst_n low mid-MUL → hi=lo=0 immediately.
- EX_MDU_SIGNED_EN: MULT −3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV −7/2 → lo=−3, hi=−1. Without the macro, MULT −3×5 gives hi=4, lo=0xFFFFFFF1.
